// File: rtl/qpsk_pkg.sv
// ============================================================================
// Module  : qpsk_pkg
// Brief   : Shared constants and FSM encodings for the QPSK deframer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package qpsk_pkg;

  localparam int SYM_W  = 2;
  localparam int BYTE_W = 8;

  localparam logic [15:0] SYNC_DEFAULT = 16'hACDD;

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_LEN     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CHECK   = 2'd3;

  function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
    return a + b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qpsk_deframer_if.sv
// ============================================================================
// Module  : qpsk_deframer_if
// Brief   : Symbol input and payload/status output bundle of the deframer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface qpsk_deframer_if;
  import qpsk_pkg::*;

  logic              valid_i;
  logic [SYM_W-1:0]  x;
  logic              valid_o;
  logic [BYTE_W-1:0] data_o;
  logic              sof_o;
  logic              eof_o;
  logic              done_o;
  logic              ok_o;
  logic              err_o;

  modport master (
    output valid_i, x,
    input  valid_o, data_o, sof_o, eof_o, done_o, ok_o, err_o
  );

  modport slave (
    input  valid_i, x,
    output valid_o, data_o, sof_o, eof_o, done_o, ok_o, err_o
  );

endinterface

`default_nettype wire

// File: rtl/qpsk_sym_packer.sv
// ============================================================================
// Module  : qpsk_sym_packer
// Brief   : Packs four 2-bit symbols MSB-first into a byte; byte is combinational.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module qpsk_sym_packer
  import qpsk_pkg::*;
(
  input  wire logic              CLK,
  input  wire logic              RST,
  input  wire logic              i_valid,
  input  wire logic [SYM_W-1:0]  i_sym,
  input  wire logic              i_clr,
  output logic                   o_byte_valid,
  output logic [BYTE_W-1:0]      o_byte
);

  logic [1:0]              r_cnt;
  logic [BYTE_W-SYM_W-1:0] r_asm;

  // The 4th symbol is appended directly so the byte is usable in its own cycle.
  assign o_byte       = {r_asm, i_sym};
  assign o_byte_valid = i_valid && !i_clr && (r_cnt == 2'd3);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= 2'd0;
      r_asm <= '0;
    end else if (i_clr) begin
      r_cnt <= 2'd0;
      r_asm <= '0;
    end else if (i_valid) begin
      r_cnt <= r_cnt + 2'd1;
      r_asm <= {r_asm[BYTE_W-2*SYM_W-1:0], i_sym};
    end
  end

endmodule

`default_nettype wire

// File: rtl/qpsk_deframer.sv
// ============================================================================
// Module  : qpsk_deframer
// Brief   : Sync hunt, length check, payload streaming and checksum verify.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module qpsk_deframer
  import qpsk_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_DEFAULT,
  parameter int          MAX_LEN   = 64
) (
  input  wire logic       CLK,
  input  wire logic       RST,
  qpsk_deframer_if.slave  bus
);

  localparam logic [BYTE_W-1:0] c_MAX_LEN = MAX_LEN[BYTE_W-1:0];

  logic [1:0]        r_state;
  logic [15:0]       r_shift;
  logic [BYTE_W-1:0] r_cnt;
  logic [BYTE_W-1:0] r_acc;
  logic              r_first;

  logic              r_valid_o;
  logic [BYTE_W-1:0] r_data_o;
  logic              r_sof_o;
  logic              r_eof_o;
  logic              r_done_o;
  logic              r_ok_o;
  logic              r_err_o;

  logic              w_clr;
  logic              w_byte_valid;
  logic [BYTE_W-1:0] w_byte;
  logic [15:0]       w_shift_nxt;

  // Packer is held cleared while hunting, so it starts fresh on the length byte.
  assign w_clr       = (r_state == ST_HUNT);
  assign w_shift_nxt = {r_shift[15-SYM_W:0], bus.x};

  qpsk_sym_packer u_packer (
    .CLK          (CLK),
    .RST          (RST),
    .i_valid      (bus.valid_i),
    .i_sym        (bus.x),
    .i_clr        (w_clr),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_HUNT;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_first   <= 1'b0;
      r_valid_o <= 1'b0;
      r_data_o  <= '0;
      r_sof_o   <= 1'b0;
      r_eof_o   <= 1'b0;
      r_done_o  <= 1'b0;
      r_ok_o    <= 1'b0;
      r_err_o   <= 1'b0;
    end else begin
      r_valid_o <= 1'b0;
      r_sof_o   <= 1'b0;
      r_eof_o   <= 1'b0;
      r_done_o  <= 1'b0;
      r_err_o   <= 1'b0;
      case (r_state)
        ST_HUNT: begin
          if (bus.valid_i) begin
            r_shift <= w_shift_nxt;
            if (w_shift_nxt == SYNC_WORD) begin
              r_state <= ST_LEN;
            end
          end
        end
        ST_LEN: begin
          if (w_byte_valid) begin
            r_acc <= '0;
            if (w_byte == '0 || w_byte > c_MAX_LEN) begin
              r_err_o <= 1'b1;
              r_shift <= '0;
              r_state <= ST_HUNT;
            end else begin
              r_cnt   <= w_byte;
              r_first <= 1'b1;
              r_state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (w_byte_valid) begin
            r_valid_o <= 1'b1;
            r_data_o  <= w_byte;
            r_sof_o   <= r_first;
            r_eof_o   <= (r_cnt == 8'd1);
            r_first   <= 1'b0;
            r_acc     <= csum_add(r_acc, w_byte);
            r_cnt     <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
              r_state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (w_byte_valid) begin
            r_done_o <= 1'b1;
            r_ok_o   <= (w_byte == r_acc);
            r_shift  <= '0;
            r_state  <= ST_HUNT;
          end
        end
        default: r_state <= ST_HUNT;
      endcase
    end
  end

  assign bus.valid_o = r_valid_o;
  assign bus.data_o  = r_data_o;
  assign bus.sof_o   = r_sof_o;
  assign bus.eof_o   = r_eof_o;
  assign bus.done_o  = r_done_o;
  assign bus.ok_o    = r_ok_o;
  assign bus.err_o   = r_err_o;

endmodule

`default_nettype wire

// File: doc/qpsk_deframer.md
Name: qpsk_deframer

Overview:
- Downstream consumer of the QPSK demapper's 2-bit symbol stream (valid/x).
- Hunts for a 16-bit sync word, then reads a length byte.
- Packs the following symbols into payload bytes and streams them out.
- Checks a trailing 8-bit additive checksum and reports frame pass/fail to the link-layer/receive FIFO.

Parameters:
- SYNC_WORD, 16'hACDD, sync pattern, MSB transmitted first.
- MAX_LEN, 64, largest legal payload length in bytes (1..255).

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous active-low reset.
- valid_i  input  1  symbol strobe from demapper.
- x  input  2  demapped symbol; x[1] is the earlier bit.
- valid_o  output  1  one-cycle strobe, data_o holds a payload byte.
- data_o  output  8  payload byte.
- sof_o  output  1  asserted with valid_o on the first payload byte.
- eof_o  output  1  asserted with valid_o on the last payload byte.
- done_o  output  1  one-cycle strobe when the checksum byte completes.
- ok_o  output  1  checksum result; qualified by done_o.
- err_o  output  1  one-cycle strobe for an illegal length field.

Behaviour:
- Interface fixed: single clock CLK; RST asynchronous, active-low. All state and outputs clear on RST low:
  - valid_o, sof_o, eof_o, done_o, ok_o, err_o = 0.
  - data_o = 0.
  - FSM in HUNT, shift register = 0.
- All state advances only on cycles with valid_i=1. Gaps of any length between symbols are legal and hold state. No backpressure.
- Bit order, MSB-first: byte = {s0, s1, s2, s3}; symbol s0 occupies bits [7:6].
- A 2-bit symbol counter counts 0..3. On count 3 with valid_i, a byte completes; the counter wraps to 0.
- FSM states:
  - HUNT: 16-bit shift register shifts in x each valid_i. When the register value after the shift equals SYNC_WORD, go to LEN and clear the symbol counter. Correlation is evaluated only in HUNT, so sync patterns inside a payload are ignored.
  - LEN: on byte completion, latch length L and clear the checksum accumulator. L==0 or L>MAX_LEN: pulse err_o and go to HUNT with the shift register cleared. Otherwise go to PAYLOAD with byte counter = L.
  - PAYLOAD: on each byte completion:
    - data_o = byte; valid_o pulses.
    - Checksum accumulator += byte (mod 256); byte counter decrements.
    - sof_o on the first byte; eof_o when the counter reaches 1, i.e. on the last byte (L==1 asserts sof_o and eof_o together).
    - After the last byte, go to CHECK.
  - CHECK: on byte completion, done_o pulses; ok_o = (byte == accumulator). Then go to HUNT with the shift register cleared.
- Latency:
  - valid_o/data_o register one cycle after the valid_i cycle carrying a byte's 4th symbol.
  - done_o/ok_o and err_o follow the same one-cycle rule.
- Strobes are single-cycle. data_o and ok_o hold their last values until the next strobe.
- Reset mid-frame aborts the frame with no done_o. Reset has priority over every event.

Decomposition:
- Shared package qpsk_pkg:
  - FSM state enumeration (HUNT, LEN, PAYLOAD, CHECK).
  - Symbol width 2.
  - Default sync constant 16'hACDD.
  - Byte width 8.
- One sub-module, qpsk_sym_packer: symbol counter plus 8-bit assembly register. It emits byte_valid/byte and has a clear input driven by the FSM.

Test Plan:
- Sync + good frame: symbols of 0xACDD, L=0x02, payload 0x12 0x34, checksum 0x46 -> valid_o twice with data 0x12 (sof_o=1) then 0x34 (eof_o=1); done_o=1 with ok_o=1.
- Bad checksum: same frame with checksum 0x47 -> both bytes delivered; done_o=1 with ok_o=0.
- Illegal length: sync then L=0x00 -> err_o pulse, no valid_o. Repeat with L=0x41 -> err_o. Following valid frame is received correctly.
- Gapped input: good frame with 0..5 idle cycles randomly between symbols -> identical output bytes. Each valid_o exactly one cycle after the 4th-symbol strobe.
- Embedded sync / L=1: payload 0xAC 0xDD with checksum 0x89 -> no re-sync, ok_o=1. Separately L=1, payload 0x7F, checksum 0x7F -> sof_o=eof_o=1 on one byte, ok_o=1.
- Reset mid-payload: drop RST after the first payload byte -> outputs clear immediately, no done_o. Next complete frame decodes with ok_o=1.
